// File: rtl/pixel_probe_if.sv
// Probe-side bundle: VGA bus in/out, window position, enable and the per-frame result handshake.
// vga_bus layout: hcount[35:25] vcount[24:14] hsync[13] vsync[12] rgb[11:0].
interface pixel_probe_if;
    localparam int VGA_BUS_SIZE = 36;

    logic                    module_en;
    logic [9:0]              xpos;
    logic [9:0]              ypos;
    logic [VGA_BUS_SIZE-1:0] vga_bus_in;
    logic [VGA_BUS_SIZE-1:0] vga_bus_out;
    logic [15:0]             result_count;
    logic                    hit;
    logic                    result_valid;
    logic                    result_ack;
    logic                    overrun;

    modport master (
        output module_en, xpos, ypos, vga_bus_in, result_ack,
        input  vga_bus_out, result_count, hit, result_valid, overrun
    );

    modport slave (
        input  module_en, xpos, ypos, vga_bus_in, result_ack,
        output vga_bus_out, result_count, hit, result_valid, overrun
    );
endinterface

// File: rtl/pixel_probe.sv
// Counts MATCH_COLOUR pixels inside a per-frame latched window; bus passes through with 1 cycle latency.
// Result is published on each vsync rising edge; an unacked result is overwritten and flagged in sticky overrun.
module pixel_probe #(
    parameter int unsigned PROBE_WIDTH   = 80,
    parameter int unsigned PROBE_HEIGHT  = 80,
    parameter logic [11:0] MATCH_COLOUR  = 12'h0F0,
    parameter int unsigned HIT_THRESHOLD = 1
) (
    input  logic         pclk,
    input  logic         rst,
    pixel_probe_if.slave bus
);
    localparam logic [10:0] W_WIDTH  = 11'(PROBE_WIDTH);
    localparam logic [10:0] W_HEIGHT = 11'(PROBE_HEIGHT);

    typedef enum logic [1:0] {IDLE, ARMED, ACCUM} state_t;

    state_t      r_state;
    logic        r_vsync_d;
    logic [9:0]  r_xpos_q;
    logic [9:0]  r_ypos_q;
    logic [15:0] r_acc;
    logic [15:0] r_result_count;
    logic        r_hit;
    logic        r_result_valid;
    logic        r_overrun;
    logic [35:0] r_bus;

    logic [10:0] w_hcount;
    logic [10:0] w_vcount;
    logic        w_vsync;
    logic [11:0] w_rgb;
    logic [10:0] w_x_end;
    logic [10:0] w_y_end;
    logic        w_fe;
    logic        w_match;

    assign w_hcount = bus.vga_bus_in[35:25];
    assign w_vcount = bus.vga_bus_in[24:14];
    assign w_vsync  = bus.vga_bus_in[12];
    assign w_rgb    = bus.vga_bus_in[11:0];

    // 11-bit window ends cannot wrap, so a window past the active area just clips
    assign w_x_end = {1'b0, r_xpos_q} + W_WIDTH;
    assign w_y_end = {1'b0, r_ypos_q} + W_HEIGHT;
    assign w_fe    = w_vsync & ~r_vsync_d;
    assign w_match = (w_hcount >= {1'b0, r_xpos_q}) && (w_hcount < w_x_end) &&
                     (w_vcount >= {1'b0, r_ypos_q}) && (w_vcount < w_y_end) &&
                     (w_rgb == MATCH_COLOUR);

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_bus     <= '0;
            r_vsync_d <= 1'b0;
        end else begin
            r_bus     <= bus.vga_bus_in;
            r_vsync_d <= w_vsync;
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_acc          <= '0;
            r_xpos_q       <= '0;
            r_ypos_q       <= '0;
            r_result_count <= '0;
            r_hit          <= 1'b0;
            r_result_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            if (w_fe) begin
                r_xpos_q <= bus.xpos;
                r_ypos_q <= bus.ypos;
            end
            // a publish later in this block overrides the ack-driven clear
            if (r_result_valid && bus.result_ack) begin
                r_result_valid <= 1'b0;
            end
            if (!bus.module_en) begin
                r_state <= IDLE;
                r_acc   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_acc   <= '0;
                        r_state <= ARMED;
                    end
                    ARMED: begin
                        if (w_fe) begin
                            r_acc   <= '0;
                            r_state <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (w_fe) begin
                            r_acc          <= '0;
                            r_result_count <= r_acc;
                            r_hit          <= ({16'h0, r_acc} >= 32'(HIT_THRESHOLD));
                            r_result_valid <= 1'b1;
                            if (r_result_valid && !bus.result_ack) begin
                                r_overrun <= 1'b1;
                            end
                        end else if (w_match && (r_acc != 16'hFFFF)) begin
                            r_acc <= r_acc + 16'd1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.vga_bus_out  = r_bus;
    assign bus.result_count = r_result_count;
    assign bus.hit          = r_hit;
    assign bus.result_valid = r_result_valid;
    assign bus.overrun      = r_overrun;
endmodule
